// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised RXD, 8N1 deserialiser with a one-entry holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps

module uart_rx #(
   parameter int CLK_FREQ_HZ = 12_000_000,
   parameter int BAUD_RATE   = 115200
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       RXD,
   input  logic       RX_READ,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   output logic       FRAME_ERR,
   output logic       PARITY_ERR,
   output logic       OVERRUN,
   output logic [2:0] dbg_state
);

   // CLKS_PER_BIT must be at least 8 for the half-bit start qualification to be meaningful.
   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int BW           = $clog2(CLKS_PER_BIT + 1);
   localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd4,
`endif
      S_STOP   = 3'd3
   } state_t;

   state_t          state, state_next;
   logic [BW-1:0]   baud_cnt, baud_next;
   logic [2:0]      bit_cnt, bit_next;
   logic [7:0]      shift, shift_next;
   logic            rx_meta, rx_sync, rx_prev;
   logic            fall;
   logic            commit;
`ifdef UART_RX_PARITY_EN
   logic            par_err_q, par_err_next;
`endif

   assign dbg_state = state;

   // Idle-high synchroniser; rx_prev only exists to find the 1->0 transition.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= RXD;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign fall = rx_prev & ~rx_sync;

   always_comb begin
      state_next = state;
      baud_next  = baud_cnt + BW'(1);
      bit_next   = bit_cnt;
      shift_next = shift;
      commit     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_next = par_err_q;
`endif
      case (state)
         S_IDLE: begin
            baud_next = '0;
            bit_next  = '0;
            if (fall) state_next = S_START;
         end
         S_START: begin
            // Mid start bit: a line that is already high again was a glitch.
            if (baud_cnt == HALF_M1) begin
               baud_next  = '0;
               state_next = rx_sync ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (baud_cnt == FULL_M1) begin
               baud_next  = '0;
               shift_next = {rx_sync, shift[7:1]};
               bit_next   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_next = S_PARITY;
`else
                  state_next = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (baud_cnt == FULL_M1) begin
               baud_next    = '0;
               par_err_next = (^shift) ^ rx_sync;
               state_next   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // Committing mid stop bit leaves half a bit to catch a back-to-back start edge.
            if (baud_cnt == FULL_M1) begin
               baud_next  = '0;
               commit     = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: begin
            baud_next  = '0;
            bit_next   = '0;
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         shift    <= shift_next;
`ifdef UART_RX_PARITY_EN
         par_err_q <= par_err_next;
`endif
      end
   end

   // Holding register handshake: RX_VALID means a byte is held; RX_READ consumes it on the
   // next edge. A commit while a byte is still held and unread is dropped and flags OVERRUN.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         RX_DATA   <= 8'h00;
         RX_VALID  <= 1'b0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         PARITY_ERR <= 1'b0;
`endif
      end else if (commit) begin
         if (!RX_VALID || RX_READ) begin
            RX_DATA   <= shift;
            RX_VALID  <= 1'b1;
            FRAME_ERR <= ~rx_sync;
            OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            PARITY_ERR <= par_err_q;
`endif
         end else begin
            OVERRUN <= 1'b1;
         end
      end else if (RX_READ && RX_VALID) begin
         RX_VALID  <= 1'b0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         PARITY_ERR <= 1'b0;
`endif
      end
   end

`ifndef UART_RX_PARITY_EN
   assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; build with UART_RX_PARITY_EN to cover parity.
`timescale 1ns/1ps

module tb_uart_rx;

   localparam int CLK_FREQ_HZ = 1600;
   localparam int BAUD_RATE   = 100;
   localparam int CPB         = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NPAR = 1;
`else
   localparam int NPAR = 0;
`endif
   localparam int EXP_LAT = 3 + CPB / 2 + 9 * CPB + NPAR * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       rx_read = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, parity_err, overrun;
   logic [2:0] dbg_state;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int rises = 0;
   int rise_cyc = 0;
   int frame_t0 = 0;
   logic valid_d = 1'b0;
   logic [7:0] exp_q[$];

   uart_rx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE)) dut (
      .CLK(clk), .RESET(rst), .RXD(rxd), .RX_READ(rx_read),
      .RX_DATA(rx_data), .RX_VALID(rx_valid), .FRAME_ERR(frame_err),
      .PARITY_ERR(parity_err), .OVERRUN(overrun), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      valid_d <= rx_valid;
      if (rx_valid && !valid_d) begin
         rises    <= rises + 1;
         rise_cyc <= cyc;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      frame_t0 = cyc;
   endtask

   // ---------------- drivers ----------------
   task automatic send_bit(input logic v);
      rxd = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
      logic par;
      par = (^b) ^ par_flip;
      @(posedge clk); #1;
      frame_t0 = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`endif
      send_bit(stop);
      rxd = 1'b1;
   endtask

   task automatic pulse_read();
      @(posedge clk); #1 rx_read = 1'b1;
      @(posedge clk); #1 rx_read = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
      n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame: got %b want 0", frame_err); end
      n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b want 0", parity_err); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
   endtask

   task automatic test_basic();
      int r0, lat;
      logic [7:0] e;
      r0 = rises;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      lat = rise_cyc - frame_t0;
      n_cmp++; if (rises !== r0 + 1) begin n_fail++; $display("FAIL basic_rises: got %0d want %0d", rises - r0, 1); end
      n_cmp++; if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d +/-1", lat, EXP_LAT); end
      n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
      n_cmp++; if (rx_data !== e) begin n_fail++; $display("FAIL basic_data: got %h want %h", rx_data, e); end
      n_cmp++; if ({frame_err, parity_err, overrun} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b want 000", {frame_err, parity_err, overrun}); end
      pulse_read();
      n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_read_valid: got %b want 0", rx_valid); end
      n_cmp++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_read_data_kept: got %h want a5", rx_data); end
   endtask

   task automatic test_back_to_back();
      int r0;
      logic [7:0] e;
      r0 = rises;
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b0, 1'b1);
      send_frame(8'hC3, 1'b0, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (rises !== r0 + 1) begin n_fail++; $display("FAIL b2b_rises: got %0d want 1", rises - r0); end
      n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
      n_cmp++; if (rx_data !== e) begin n_fail++; $display("FAIL b2b_data: got %h want %h", rx_data, e); end
      n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
      n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL b2b_frame: got %b want 0", frame_err); end
      pulse_read();
      n_cmp++; if ({rx_valid, frame_err, parity_err, overrun} !== 4'b0000) begin n_fail++; $display("FAIL b2b_read_clear: got %b want 0000", {rx_valid, frame_err, parity_err, overrun}); end
   endtask

   task automatic test_stuck_low();
      int r0;
      logic [7:0] e;
      rxd = 1'b0;
      do_reset();
      r0 = rises;
      exp_q.push_back(8'h00);
      repeat (EXP_LAT + 8) @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (rises !== r0 + 1) begin n_fail++; $display("FAIL stuck_rises: got %0d want 1", rises - r0); end
      n_cmp++; if (rx_data !== e) begin n_fail++; $display("FAIL stuck_data: got %h want %h", rx_data, e); end
      n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL stuck_frame: got %b want 1", frame_err); end
      n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL stuck_parity: got %b want 0", parity_err); end
      pulse_read();
      repeat (100 * CPB) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (rises !== r0 + 1) begin n_fail++; $display("FAIL stuck_extra_frames: got %0d want 1", rises - r0); end
      n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL stuck_valid: got %b want 0", rx_valid); end
      n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL stuck_state: got %0d want 0", dbg_state); end
      @(posedge clk); #1 rxd = 1'b1;
      repeat (4) @(posedge clk);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      send_frame(8'h07, 1'b1, 1'b1);
      @(negedge clk);
      n_cmp++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_bad_flag: got %b want 1", parity_err); end
      n_cmp++; if (rx_data !== 8'h07) begin n_fail++; $display("FAIL parity_bad_data: got %h want 07", rx_data); end
      pulse_read();
      send_frame(8'h07, 1'b0, 1'b1);
      @(negedge clk);
      n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_good_flag: got %b want 0", parity_err); end
      n_cmp++; if (rx_data !== 8'h07) begin n_fail++; $display("FAIL parity_good_data: got %h want 07", rx_data); end
      n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL parity_good_valid: got %b want 1", rx_valid); end
      pulse_read();
   endtask
`endif

   task automatic test_glitch();
      int r0;
      logic [7:0] e;
      r0 = rises;
      @(posedge clk); #1 rxd = 1'b0;
      repeat (4) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL glitch_state: got %0d want 0", dbg_state); end
      n_cmp++; if (rises !== r0) begin n_fail++; $display("FAIL glitch_valid: got %0d rises want 0", rises - r0); end
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b0, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (rx_data !== e) begin n_fail++; $display("FAIL glitch_next_data: got %h want %h", rx_data, e); end
      n_cmp++; if ({rx_valid, frame_err, parity_err, overrun} !== 4'b1000) begin n_fail++; $display("FAIL glitch_next_flags: got %b want 1000", {rx_valid, frame_err, parity_err, overrun}); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] e;
      @(posedge clk); #1;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      n_cmp++; if (dbg_state !== 3'd2) begin n_fail++; $display("FAIL mid_state_before: got %0d want 2", dbg_state); end
      rst = 1'b1;
      #2;
      n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data: got %h want 00", rx_data); end
      n_cmp++; if ({rx_valid, frame_err, parity_err, overrun} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_flags: got %b want 0000", {rx_valid, frame_err, parity_err, overrun}); end
      n_cmp++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL mid_rst_state: got %0d want 0", dbg_state); end
      rxd = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b0, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (rx_data !== e) begin n_fail++; $display("FAIL mid_next_data: got %h want %h", rx_data, e); end
      n_cmp++; if ({rx_valid, frame_err, parity_err, overrun} !== 4'b1000) begin n_fail++; $display("FAIL mid_next_flags: got %b want 1000", {rx_valid, frame_err, parity_err, overrun}); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stuck_low();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_glitch();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
